qnn_bseg_unit: RTL and testbench
================================

# qnn_bseg_unit

Parametrised multi-lane execution unit for the custom QNN bit-segment instructions (opcode OP_BS, funct3 SET/GET/IP/GP0..GP4). It sits beside the integer ALU in the execute stage and takes decoded operands from issue. It computes low-precision signed or unsigned dot products bit-serially over NUM_LANES popcount lanes, accumulating into an XLEN-bit accumulator. Unused GP encodings are flagged illegal.

## Interface
- XLEN, 64, datapath and accumulator width
- MAX_BITS, 8, maximum element precision; power of two, ≤16, divides XLEN; E = XLEN/MAX_BITS elements per word
- NUM_LANES, 4, bit-plane pairs processed per cycle; 1..MAX_BITS*MAX_BITS
- clk_i  in  1  clock; single clock domain
- rstn_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  unit accepts request
- req_funct3_i  in  3  op_funct3_bs_t
- req_rs1_i  in  XLEN  operand 1
- req_rs2_i  in  XLEN  operand 2 / selector
- kill_i  in  1  flush; aborts in-flight op
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  consumer accepts response
- resp_data_o  out  XLEN  result
- resp_illegal_o  out  1  illegal-instruction flag, qualified by resp_valid_o

## Operation
- State: ACC (XLEN), W (XLEN), CFG {a_bits-1[3:0], w_bits-1[7:4], a_signed[8], w_signed[9]}.
- Reset values: ACC=0, W=0, CFG fields = MAX_BITS-1 with both signed flags 0; resp_valid_o=0, resp_data_o=0, resp_illegal_o=0, req_ready_o=1.
- Element i occupies bits [i*MAX_BITS +: MAX_BITS]. Only the low n bits are used; higher bits are ignored.
- SET: rs2[0]=0 writes CFG from rs1[9:0], with each bits field saturating to MAX_BITS-1. rs2[0]=1 writes W=rs1. Response data 0.
- GET: rs2[0]=0 returns ACC. rs2[0]=1 returns zero-extended CFG.
- IP: A=rs1. For each plane pair (p,q), p<a_bits, q<w_bits, the term is popcount(Aplane_p & Wplane_q) << (p+q).
  - The term is negated iff exactly one of the following holds: p is the MSB plane of a signed A, or q is the MSB plane of a signed W.
  - Pairs are ordered q-major, p-minor. NUM_LANES pairs are issued per cycle; the last cycle masks unused lanes.
  - Partial sum is kept in a separate register. ACC += sum, computed mod 2^XLEN.
  - Response returns the new ACC.
- GP0: returns old ACC and clears ACC.
- GP1–GP4: resp_illegal_o=1, data 0, no state change.
- FSM states:
  - IDLE: req_ready_o=1. On req_valid_i&&!kill_i, go to BUSY if IP, else RESP.
  - BUSY: count C=ceil(a_bits*w_bits/NUM_LANES) cycles. On the last cycle, commit ACC and go to RESP.
  - RESP: resp_valid_o=1. Go to IDLE on resp_ready_i.
- CFG/W/ACC updates for SET/GP0 commit at acceptance.

## Timing
- Non-IP ops: accepted at cycle N, resp_valid_o asserted at N+1.
- IP: resp_valid_o asserted at N+1+C. C=1 for 2x2 bits with 4 lanes; C=16 for 8x8 bits with 4 lanes.
- One request outstanding; req_ready_o=0 in BUSY and RESP. No same-cycle response-to-request overlap; next accept is the cycle after the response handshake.
- resp_data_o and resp_illegal_o are stable while resp_valid_o && !resp_ready_i.
- kill_i behaviour:
  - BUSY: next state IDLE, partial sum discarded, ACC unchanged, no response.
  - RESP: response dropped; committed state kept.
  - IDLE: a request presented in the same cycle is not accepted.
- Reset mid-operation returns to IDLE with reset values immediately (asynchronous).
- CFG written by SET is used by the next IP.

## Structure
- Shared package (riscv_pkg or a new qnn_bseg_pkg):
  - bs_cfg_t packed struct
  - bs_state_t enum {BS_IDLE, BS_BUSY, BS_RESP}
  - SET/GET selector constants
  - reuse the existing op_funct3_bs_t
- Sub-module qnn_bseg_lane: combinational E-bit AND, popcount, shift by p+q, conditional negate.
- Top instantiates NUM_LANES lanes, an adder tree, the pair counter, and the FSM.

## Test plan
- Reset, then GET rs2=0 → 0; GET rs2=1 → 0x77.
- SET CFG rs1=0x11; SET W=0x0101010101010101; IP rs1=0x0303030303030303 → resp 0x18 two cycles after accept.
- GP0 → 0x18, ACC=0. SET CFG=0x377; W=all 0xFF; IP rs1=0x05 → 0xFFFFFFFFFFFFFFFB after 17 cycles.
- IP with CFG=0x77, kill_i at BUSY cycle 5 → no resp_valid_o; GET returns the prior ACC.
- GP2 → resp_illegal_o=1, data 0; GET shows ACC unchanged.
- Hold resp_ready_i=0 for 5 cycles → resp_valid_o and data held, req_ready_o=0; handshake, then IDLE the next cycle.

Source files
------------

// File: rtl/qnn_bseg_pkg.sv
// ============================================================================
// qnn_bseg_pkg : shared types and helpers for the QNN bit-segment unit
// Revision     : 1.0
// ============================================================================
`default_nettype none

package qnn_bseg_pkg;

    typedef enum logic [2:0] {
        F3_SET = 3'd0,
        F3_GET = 3'd1,
        F3_IP  = 3'd2,
        F3_GP0 = 3'd3,
        F3_GP1 = 3'd4,
        F3_GP2 = 3'd5,
        F3_GP3 = 3'd6,
        F3_GP4 = 3'd7
    } op_funct3_bs_t;

    typedef struct packed {
        logic       w_signed;
        logic       a_signed;
        logic [3:0] w_bits_m1;
        logic [3:0] a_bits_m1;
    } bs_cfg_t;

    typedef enum logic [1:0] {
        BS_IDLE = 2'd0,
        BS_BUSY = 2'd1,
        BS_RESP = 2'd2
    } bs_state_t;

    localparam logic SEL_SET_CFG = 1'b0;
    localparam logic SEL_SET_W   = 1'b1;
    localparam logic SEL_GET_ACC = 1'b0;
    localparam logic SEL_GET_CFG = 1'b1;

    // Precision fields are stored as bits-1 and clamp to the widest supported element.
    function automatic bs_cfg_t cfg_from_word(input logic [9:0] raw, input logic [3:0] max_m1);
        bs_cfg_t c;
        c.w_signed  = raw[9];
        c.a_signed  = raw[8];
        c.w_bits_m1 = (raw[7:4] > max_m1) ? max_m1 : raw[7:4];
        c.a_bits_m1 = (raw[3:0] > max_m1) ? max_m1 : raw[3:0];
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/qnn_bseg_if.sv
// ============================================================================
// qnn_bseg_if : request/response handshake bundle for qnn_bseg_unit
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface qnn_bseg_if
    import qnn_bseg_pkg::*;
#(
    parameter int XLEN = 64
);
    logic                req_valid;
    logic                req_ready;
    op_funct3_bs_t       req_funct3;
    logic [XLEN-1:0]     req_rs1;
    logic [XLEN-1:0]     req_rs2;
    logic                resp_valid;
    logic                resp_ready;
    logic [XLEN-1:0]     resp_data;
    logic                resp_illegal;

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_illegal
    );

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, resp_ready,
        output req_ready, resp_valid, resp_data, resp_illegal
    );
endinterface

`default_nettype wire

// File: rtl/qnn_bseg_lane.sv
// ============================================================================
// qnn_bseg_lane : one bit-plane pair -> signed, weighted popcount term
// Revision      : 1.0
// ============================================================================
`default_nettype none

module qnn_bseg_lane #(
    parameter int XLEN     = 64,
    parameter int MAX_BITS = 8
) (
    input  wire logic [XLEN-1:0] a_i,
    input  wire logic [XLEN-1:0] w_i,
    input  wire logic [3:0]      p_i,
    input  wire logic [3:0]      q_i,
    input  wire logic            en_i,
    input  wire logic            neg_i,
    output logic      [XLEN-1:0] term_o
);
    localparam int E  = XLEN / MAX_BITS;
    localparam int PW = $clog2(E + 1);

    logic [PW-1:0]   pop;
    logic [XLEN-1:0] shifted;
    logic [4:0]      shamt;

    always_comb begin
        pop = '0;
        for (int i = 0; i < E; i++) begin
            pop = pop + PW'(a_i[i*MAX_BITS + int'(p_i)] & w_i[i*MAX_BITS + int'(q_i)]);
        end
        shamt   = {1'b0, p_i} + {1'b0, q_i};
        shifted = XLEN'(pop) << shamt;
        term_o  = '0;
        if (en_i) begin
            term_o = neg_i ? (~shifted + XLEN'(1)) : shifted;
        end
    end

endmodule

`default_nettype wire

// File: rtl/qnn_bseg_unit.sv
// ============================================================================
// qnn_bseg_unit : bit-serial low-precision dot-product unit (SET/GET/IP/GPx)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module qnn_bseg_unit
    import qnn_bseg_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int MAX_BITS  = 8,
    parameter int NUM_LANES = 4
) (
    input  wire logic    clk_i,
    input  wire logic    rstn_i,
    input  wire logic    kill_i,
    qnn_bseg_if.slave    bus
);
    localparam logic [3:0] MAX_M1 = 4'(MAX_BITS - 1);

    bs_state_t       state_q, state_d;
    bs_cfg_t         cfg_q;
    logic [XLEN-1:0] acc_q, w_q, a_q, sum_q, resp_data_q;
    logic            resp_illegal_q;
    logic [3:0]      p_q;
    logic [4:0]      q_q;

    logic            accept, busy_step, last;
    logic            req_ready, resp_valid;
    logic [4:0]      w_bits;
    logic [3:0]      lp [NUM_LANES+1];
    logic [4:0]      lq [NUM_LANES+1];
    logic [XLEN-1:0] terms [NUM_LANES];
    logic [XLEN-1:0] cyc_sum, acc_new;

    assign w_bits = {1'b0, cfg_q.w_bits_m1} + 5'd1;

    // Walk pairs q-major/p-minor; once q reaches w_bits the position parks there.
    always_comb begin
        lp[0] = p_q;
        lq[0] = q_q;
        for (int l = 1; l <= NUM_LANES; l++) begin
            lp[l] = lp[l-1];
            lq[l] = lq[l-1];
            if (lq[l-1] < w_bits) begin
                if (lp[l-1] == cfg_q.a_bits_m1) begin
                    lp[l] = '0;
                    lq[l] = lq[l-1] + 5'd1;
                end else begin
                    lp[l] = lp[l-1] + 4'd1;
                end
            end
        end
    end

    assign last = (lq[NUM_LANES] >= w_bits);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        qnn_bseg_lane #(.XLEN(XLEN), .MAX_BITS(MAX_BITS)) u_lane (
            .a_i    (a_q),
            .w_i    (w_q),
            .p_i    (lp[l]),
            .q_i    (lq[l][3:0]),
            .en_i   (lq[l] < w_bits),
            .neg_i  ((cfg_q.a_signed && (lp[l] == cfg_q.a_bits_m1)) ^
                     (cfg_q.w_signed && (lq[l] == {1'b0, cfg_q.w_bits_m1}))),
            .term_o (terms[l])
        );
    end

    always_comb begin
        cyc_sum = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            cyc_sum = cyc_sum + terms[l];
        end
    end

    assign acc_new = acc_q + sum_q + cyc_sum;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= BS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        busy_step  = 1'b0;
        unique case (state_q)
            BS_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid && !kill_i) begin
                    accept  = 1'b1;
                    state_d = (bus.req_funct3 == F3_IP) ? BS_BUSY : BS_RESP;
                end
            end
            BS_BUSY: begin
                if (kill_i) begin
                    state_d = BS_IDLE;
                end else begin
                    busy_step = 1'b1;
                    if (last) state_d = BS_RESP;
                end
            end
            BS_RESP: begin
                resp_valid = !kill_i;
                if (kill_i || bus.resp_ready) state_d = BS_IDLE;
            end
            default: state_d = BS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc_q          <= '0;
            w_q            <= '0;
            a_q            <= '0;
            sum_q          <= '0;
            cfg_q          <= '{w_signed: 1'b0, a_signed: 1'b0, w_bits_m1: MAX_M1, a_bits_m1: MAX_M1};
            p_q            <= '0;
            q_q            <= '0;
            resp_data_q    <= '0;
            resp_illegal_q <= 1'b0;
        end else if (accept) begin
            resp_data_q    <= '0;
            resp_illegal_q <= 1'b0;
            unique case (bus.req_funct3)
                F3_SET: begin
                    if (bus.req_rs2[0] == SEL_SET_W) w_q <= bus.req_rs1;
                    else                             cfg_q <= cfg_from_word(bus.req_rs1[9:0], MAX_M1);
                end
                F3_GET: begin
                    resp_data_q <= (bus.req_rs2[0] == SEL_GET_CFG) ?
                                   {{(XLEN-10){1'b0}}, cfg_q} : acc_q;
                end
                F3_IP: begin
                    a_q   <= bus.req_rs1;
                    sum_q <= '0;
                    p_q   <= '0;
                    q_q   <= '0;
                end
                F3_GP0: begin
                    resp_data_q <= acc_q;
                    acc_q       <= '0;
                end
                default: resp_illegal_q <= 1'b1;
            endcase
        end else if (busy_step) begin
            sum_q <= sum_q + cyc_sum;
            p_q   <= lp[NUM_LANES];
            q_q   <= lq[NUM_LANES];
            if (last) begin
                acc_q       <= acc_new;
                resp_data_q <= acc_new;
            end
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.resp_valid   = resp_valid;
    assign bus.resp_data    = resp_data_q;
    assign bus.resp_illegal = resp_illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_qnn_bseg_unit.sv
// ============================================================================
// tb_qnn_bseg_unit : directed scoreboard bench for qnn_bseg_unit
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_qnn_bseg_unit;
    import qnn_bseg_pkg::*;

    localparam int XLEN = 64;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            ill;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic kill = 1'b0;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    qnn_bseg_if #(.XLEN(XLEN)) bus ();

    qnn_bseg_unit #(.XLEN(XLEN), .MAX_BITS(8), .NUM_LANES(4)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .kill_i (kill),
        .bus    (bus)
    );

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every completed response handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (rstn && bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_data", bus.resp_data, e.data);
                chk("resp_illegal", {63'd0, bus.resp_illegal}, {63'd0, e.ill});
            end
        end
    end

    task automatic issue(input op_funct3_bs_t f, input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                         input logic [XLEN-1:0] ed, input logic ei, input int elat, input string nm);
        int lat;
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_funct3 = f;
        bus.req_rs1    = rs1;
        bus.req_rs2    = rs2;
        sb.push_back('{data: ed, ill: ei});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(elat));
        @(posedge clk); #1;
        chk({nm, "_idle_after"}, {63'd0, bus.req_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_funct3 = F3_SET;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        #1;
        chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        chk("rst_resp_data", bus.resp_data, 64'd0);
        chk("rst_resp_illegal", {63'd0, bus.resp_illegal}, 64'd0);

        issue(F3_GET, 64'd0, 64'd0, 64'd0, 1'b0, 0, "get_acc_rst");
        issue(F3_GET, 64'd0, 64'd1, 64'h77, 1'b0, 0, "get_cfg_rst");
        issue(F3_SET, 64'h11, 64'd0, 64'd0, 1'b0, 0, "set_cfg_2x2");
        issue(F3_SET, 64'h0101010101010101, 64'd1, 64'd0, 1'b0, 0, "set_w_ones");
        issue(F3_IP, 64'h0303030303030303, 64'd0, 64'h18, 1'b0, 1, "ip_2x2");
        // High element bits beyond the 2-bit precision must be ignored.
        issue(F3_IP, 64'hFFFFFFFFFFFFFFFF, 64'd0, 64'h30, 1'b0, 1, "ip_2x2_hibits");
        issue(F3_GP0, 64'd0, 64'd0, 64'h30, 1'b0, 0, "gp0");
        issue(F3_GET, 64'd0, 64'd0, 64'd0, 1'b0, 0, "get_acc_cleared");
        issue(F3_SET, 64'h377, 64'd0, 64'd0, 1'b0, 0, "set_cfg_signed");
        issue(F3_GET, 64'd0, 64'd1, 64'h377, 1'b0, 0, "get_cfg_signed");
        issue(F3_SET, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0, 1'b0, 0, "set_w_all1");
        issue(F3_IP, 64'h05, 64'd0, 64'hFFFFFFFFFFFFFFFB, 1'b0, 16, "ip_8x8_signed");
        issue(F3_SET, 64'h3FF, 64'd0, 64'd0, 1'b0, 0, "set_cfg_sat");
        issue(F3_GET, 64'd0, 64'd1, 64'h377, 1'b0, 0, "get_cfg_sat");
        issue(F3_SET, 64'h077, 64'd0, 64'd0, 1'b0, 0, "set_cfg_unsigned");
        issue(F3_IP, 64'h05, 64'd0, 64'h4F6, 1'b0, 16, "ip_8x8_unsigned");

        // IP aborted by kill in its fifth busy cycle: no response, ACC unchanged.
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_funct3 = F3_IP;
        bus.req_rs1    = 64'h05;
        bus.req_rs2    = 64'd0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("busy_req_ready", {63'd0, bus.req_ready}, 64'd0);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_idle", {63'd0, bus.req_ready}, 64'd1);
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (bus.resp_valid) seen++;
            end
            chk("kill_no_resp", 64'(seen), 64'd0);
        end
        issue(F3_GET, 64'd0, 64'd0, 64'h4F6, 1'b0, 0, "get_acc_after_kill");

        issue(F3_GP2, 64'h1234, 64'd1, 64'd0, 1'b1, 0, "gp2_illegal");
        issue(F3_GET, 64'd0, 64'd0, 64'h4F6, 1'b0, 0, "get_acc_after_gp2");
        issue(F3_GP4, 64'h1, 64'd0, 64'd0, 1'b1, 0, "gp4_illegal");

        // Back-pressure: response must hold while the consumer stalls.
        bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_funct3 = F3_GET;
        bus.req_rs1    = 64'd0;
        bus.req_rs2    = 64'd0;
        sb.push_back('{data: 64'h4F6, ill: 1'b0});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {63'd0, bus.resp_valid}, 64'd1);
            chk("hold_data", bus.resp_data, 64'h4F6);
            chk("hold_req_ready", {63'd0, bus.req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_valid", {63'd0, bus.resp_valid}, 64'd0);
        chk("post_hs_req_ready", {63'd0, bus.req_ready}, 64'd1);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
